// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Port vectors are flat; port_slice extracts one port's field.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;
    localparam int VEC_MAX    = 1024;

    // Field idx of width w (w <= 64) from a flat packed port vector.
    function automatic logic [63:0] port_slice(
        input logic [VEC_MAX-1:0] vec,
        input int                 idx,
        input int                 w
    );
        logic [63:0] mask;
        mask = ~(~64'd0 << w);
        return 64'(vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy flop per register.
// A reservation beats a same-cycle clear; bypass hits mask rd_busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rsv,
    input  logic [ADDR_W-1:0]        i_rsv_addr,
    input  logic [DEPTH-1:0]         i_clr,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    input  logic [NUM_RD-1:0]        i_hit,
    output logic [DEPTH-1:0]         o_busy_vec,
    output logic [NUM_RD-1:0]        o_rd_busy
);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_next;
    logic [ADDR_W-1:0] w_ra;

    // Next busy state: writes clear, a reservation then sets.
    always_comb begin
        w_next = r_busy & ~i_clr;
        if (i_rsv) w_next[i_rsv_addr] = 1'b1;
    end

    // Busy flops, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_next;
    end

    // Per-port stall flag, masked by same-cycle forwarding.
    always_comb begin
        o_rd_busy = '0;
        w_ra      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra = ADDR_W'(port_slice(VEC_MAX'(i_rd_addr), i, ADDR_W));
            o_rd_busy[i] = r_busy[w_ra] & ~((BYPASS != 0) & i_hit[i]);
            if (ZERO_REG != 0 && w_ra == ADDR_W'(ZERO_ADDR))
                o_rd_busy[i] = 1'b0;
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional bypass and a RAW scoreboard.
// Higher-index write ports win collisions, both in storage and bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DATA_W-1:0] r_mem   [DEPTH];
    logic [ADDR_W-1:0] w_waddr [NUM_WR];
    logic [DATA_W-1:0] w_wdata [NUM_WR];
    logic [NUM_WR-1:0] w_wen;
    logic [DEPTH-1:0]  w_clr;
    logic [NUM_RD-1:0] w_hit;
    logic              w_rsv;
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] w_byp;

    // Decode write ports; reg-0 writes and writes under reset are dropped.
    always_comb begin
        w_wen = '0;
        w_clr = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            w_waddr[k] = ADDR_W'(port_slice(VEC_MAX'(wr_addr), k, ADDR_W));
            w_wdata[k] = DATA_W'(port_slice(VEC_MAX'(wr_data), k, DATA_W));
            w_wen[k]   = wr_en[k] & ~rst;
            if (ZERO_REG != 0 && w_waddr[k] == ADDR_W'(ZERO_ADDR))
                w_wen[k] = 1'b0;
            if (w_wen[k]) w_clr[w_waddr[k]] = 1'b1;
        end
    end

    // Reservations of reg 0 are meaningless when it is hardwired.
    always_comb begin
        w_rsv = rsv_en & ~rst;
        if (ZERO_REG != 0 && rsv_addr == ADDR_W'(ZERO_ADDR))
            w_rsv = 1'b0;
    end

    // Storage; later ports overwrite earlier ones on collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++)
                if (w_wen[k]) r_mem[w_waddr[k]] <= w_wdata[k];
        end
    end

    // Read muxing with forwarding from the highest matching write port.
    always_comb begin
        rd_data = '0;
        w_hit   = '0;
        w_ra    = '0;
        w_rd    = '0;
        w_byp   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra  = ADDR_W'(port_slice(VEC_MAX'(rd_addr), i, ADDR_W));
            w_rd  = r_mem[w_ra];
            w_byp = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_wen[k] && w_waddr[k] == w_ra) begin
                    w_hit[i] = 1'b1;
                    w_byp    = w_wdata[k];
                end
            end
            if (BYPASS != 0 && w_hit[i]) w_rd = w_byp;
            if (ZERO_REG != 0 && w_ra == ADDR_W'(ZERO_ADDR)) w_rd = '0;
            rd_data[i*DATA_W +: DATA_W] = w_rd;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_rsv      (w_rsv),
        .i_rsv_addr (rsv_addr),
        .i_clr      (w_clr),
        .i_rd_addr  (rd_addr),
        .i_hit      (w_hit),
        .o_busy_vec (busy_vec),
        .o_rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassed and a non-bypassed copy
// share stimulus; each is checked against hand-computed values.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] b_rd_data, n_rd_data;
    logic [1:0]  b_rd_busy, n_rd_busy;
    logic [31:0] b_busy_vec, n_busy_vec;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) u_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(b_busy_vec)
    );

    regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)) u_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(n_rd_data),
        .rd_busy(n_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(n_busy_vec)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  ra;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] bd0, bd1;
        logic [1:0]  bbz;
        logic [31:0] nd0, nd1;
        logic [1:0]  nbz;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0,
                         input logic [31:0] wd0, input logic [4:0] wa1,
                         input logic [31:0] wd1, input logic rsv,
                         input logic [4:0] ra, input logic [4:0] r0,
                         input logic [4:0] r1);
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rsv_en   = rsv;
        rsv_addr = ra;
        rd_addr  = {r1, r0};
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we wa0 wd0 wa1 wd1 rsv ra r0 r1 | bd0 bd1 bbz | nd0 nd1 nbz
        tbl[0] = '{2'b01, 5'd1, 32'h11, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2,
                   32'h11, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[1] = '{2'b11, 5'd2, 32'h22, 5'd4, 32'h44, 1'b0, 5'd0, 5'd1, 5'd4,
                   32'h11, 32'h44, 2'b00, 32'h11, 32'h0, 2'b00};
        tbl[2] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd2, 5'd4,
                   32'h22, 32'h44, 2'b00, 32'h22, 32'h44, 2'b00};
        tbl[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd1,
                   32'h44, 32'h11, 2'b01, 32'h44, 32'h11, 2'b01};
        tbl[4] = '{2'b10, 5'd0, 32'h0, 5'd4, 32'h4444, 1'b0, 5'd0, 5'd4, 5'd4,
                   32'h4444, 32'h4444, 2'b00, 32'h44, 32'h44, 2'b11};
        tbl[5] = '{2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 1'b1, 5'd6, 5'd4, 5'd6,
                   32'h4444, 32'h66, 2'b00, 32'h4444, 32'h0, 2'b00};
        tbl[6] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd1,
                   32'h66, 32'h11, 2'b01, 32'h66, 32'h11, 2'b01};
        tbl[7] = '{2'b11, 5'd3, 32'hA, 5'd3, 32'hB, 1'b0, 5'd0, 5'd3, 5'd6,
                   32'hB, 32'h66, 2'b10, 32'h0, 32'h66, 2'b10};
        tbl[8] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd6,
                   32'hB, 32'h66, 2'b10, 32'hB, 32'h66, 2'b10};

        // Reset state
        rst = 1'b1;
        idle();
        rd_addr = {5'd3, 5'd1};
        cyc();
        cyc();
        chk("rst_rd_data", b_rd_data, 64'd0);
        chk("rst_busy_vec", {b_busy_vec, n_busy_vec}, 64'd0);
        chk("rst_rd_busy", {b_rd_busy, n_rd_busy}, 64'd0);
        rst = 1'b0;
        cyc();

        // Table of single-cycle vectors
        for (int e = 0; e < 9; e++) begin
            drive(tbl[e].we, tbl[e].wa0, tbl[e].wd0, tbl[e].wa1, tbl[e].wd1,
                  tbl[e].rsv, tbl[e].ra, tbl[e].r0, tbl[e].r1);
            #1;
            chk($sformatf("v%0d_b_rd0", e), b_rd_data[31:0], tbl[e].bd0);
            chk($sformatf("v%0d_b_rd1", e), b_rd_data[63:32], tbl[e].bd1);
            chk($sformatf("v%0d_b_busy", e), b_rd_busy, tbl[e].bbz);
            chk($sformatf("v%0d_n_rd0", e), n_rd_data[31:0], tbl[e].nd0);
            chk($sformatf("v%0d_n_rd1", e), n_rd_data[63:32], tbl[e].nd1);
            chk($sformatf("v%0d_n_busy", e), n_rd_busy, tbl[e].nbz);
            cyc();
        end

        // Bypass: write r7 and read it on port 1 in the same cycle
        drive(2'b01, 5'd7, 32'h12345678, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
        #1;
        chk("byp_same", b_rd_data[63:32], 64'h12345678);
        chk("nobyp_same", n_rd_data[63:32], 64'h0);
        cyc();
        idle();
        rd_addr = {5'd7, 5'd0};
        #1;
        chk("nobyp_next", n_rd_data[63:32], 64'h12345678);

        // Zero register ignores writes and reservations
        drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        chk("zero_same_rd", b_rd_data[31:0], 64'h0);
        chk("zero_same_bz", b_rd_busy, 64'h0);
        cyc();
        idle();
        #1;
        chk("zero_rd", {b_rd_data[31:0], n_rd_data[31:0]}, 64'h0);
        chk("zero_busy_vec", {b_busy_vec[0], n_busy_vec[0]}, 64'h0);
        chk("zero_rd_busy", {b_rd_busy, n_rd_busy}, 64'h0);

        // Scoreboard timeline for r9: reserve at t, write at t+3
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        #1;
        chk("sb_t0", b_rd_busy[0], 64'h0);
        cyc();
        idle();
        rd_addr = {5'd0, 5'd9};
        #1;
        chk("sb_t1", {b_rd_busy[0], n_rd_busy[0]}, 64'h3);
        cyc();
        chk("sb_t2", {b_rd_busy[0], n_rd_busy[0]}, 64'h3);
        cyc();
        drive(2'b01, 5'd9, 32'h55, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
        chk("sb_t3_b", b_rd_busy[0], 64'h0);
        chk("sb_t3_n", n_rd_busy[0], 64'h1);
        chk("sb_t3_vec", b_busy_vec[9], 64'h1);
        cyc();
        idle();
        rd_addr = {5'd0, 5'd9};
        #1;
        chk("sb_t4_vec", {b_busy_vec[9], n_busy_vec[9]}, 64'h0);
        chk("sb_t4_data", n_rd_data[31:0], 64'h55);

        // Reserve and write the same register in one cycle
        drive(2'b01, 5'd10, 32'h77, 5'd0, 32'd0, 1'b1, 5'd10, 5'd10, 5'd0);
        cyc();
        idle();
        rd_addr = {5'd0, 5'd10};
        #1;
        chk("rsvwr_vec", {b_busy_vec[10], n_busy_vec[10]}, 64'h3);
        chk("rsvwr_data", {b_rd_data[31:0], n_rd_data[31:0]},
            64'h00000077_00000077);
        chk("rsvwr_rd_busy", b_rd_busy[0], 64'h1);

        // Asynchronous reset mid-cycle wipes data and reservations
        drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b1, 5'd12, 5'd5, 5'd0);
        cyc();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("pre_rst_data", n_rd_data[31:0], 64'hDEADBEEF);
        chk("pre_rst_busy", b_busy_vec[12], 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_data", {b_rd_data, n_rd_data[31:0]}, 64'h0);
        chk("arst_busy_vec", {b_busy_vec, n_busy_vec}, 64'h0);
        // Writes presented under reset must not forward or store
        drive(2'b01, 5'd5, 32'hCAFE, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
        #1;
        chk("arst_wr_ignored", b_rd_data[31:0], 64'h0);
        cyc();
        idle();
        rd_addr = {5'd0, 5'd5};
        rst = 1'b0;
        #1;
        chk("post_rst_data", {b_rd_data[31:0], n_rd_data[31:0]}, 64'h0);
        chk("post_rst_busy", {b_busy_vec, n_busy_vec}, 64'h0);

        // First edge after reset performs a normal write
        drive(2'b01, 5'd5, 32'h5A5A, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        cyc();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("post_rst_wr", n_rd_data[31:0], 64'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath. It generalises the single-write, two-read bank to N read and M write ports, optional write-to-read bypass and an asynchronous clear. A per-register pending-write scoreboard lets the multicycle and pipelined cores stall on RAW hazards. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  read register has a pending write not satisfied this cycle
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- rsv_en  in  1  reserve a destination (set busy)
- rsv_addr  in  ADDR_W  destination to reserve
- busy_vec  out  DEPTH  scoreboard state, bit r = register r pending

## Operation
- Write: on posedge, each port k with wr_en[k] stores wr_data[k] to wr_addr[k]. Writes to reg 0 are dropped when ZERO_REG=1.
- Write collision (both ports, same address): higher-index port wins.
- Read: rd_data[i] = mem[rd_addr[i]]. Returns 0 for reg 0 when ZERO_REG=1.
- Bypass (BYPASS=1): if any wr_en[k] targets rd_addr[i] (and it is not a dropped reg-0 write), rd_data[i] = wr_data of the highest such k.
- Scoreboard, per register r, next busy[r]:
  - 1 if rsv_en and rsv_addr==r;
  - else 0 if any valid write targets r;
  - else hold.
- Reserve and write to the same register in one cycle: busy stays 1, because the new producer owns it.
- rd_busy[i] = busy[rd_addr[i]] & ~(BYPASS & bypass hit on port i). It is always 0 for reg 0 when ZERO_REG=1.
- Reserving an already-busy register: it stays busy, no error. Writing a non-busy register: the data is stored and busy stays 0.
- Reset: while rst=1, all registers and busy_vec are 0 immediately, independent of clk. rd_data therefore reads 0 and rd_busy is 0. Writes and reservations are ignored while rst=1.

## Timing
- Read latency: 0 cycles, combinational from rd_addr, state and (bypass) write ports.
- Write visibility: next cycle when BYPASS=0; same cycle when BYPASS=1.
- busy set/clear visible on busy_vec and rd_busy the cycle after the edge.
- Reset assertion: outputs 0 within the same cycle. Deassertion is synchronised externally. The first edge with rst=0 performs normal writes.
- Reset mid-operation: in-flight reservations are lost and all registers read 0 afterwards.
- No handshake: the caller stalls on rd_busy. The block never back-pressures writes.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W;
  - a function slicing the packed port vectors by index;
  - the ZERO_ADDR constant.
- Sub-module regfile_scoreboard (DEPTH busy flops, set/clear priority, rd_busy generation, bypass-hit inputs).
- Storage, write-port priority and read/bypass muxing stay in regfile_mp.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst asynchronously mid-cycle. Required: rd_data(r5)=0 before the next edge and busy_vec=0.
- Bypass: BYPASS=1, write 0x12345678 to r7 and read r7 on port 1 in the same cycle. Required: rd_data=0x12345678 in the same cycle. With BYPASS=0, the old value (0) appears that cycle and 0x12345678 the next.
- Zero register: write 0xFFFFFFFF to r0 and rsv_en on r0. Required: reading r0 gives 0, busy_vec[0]=0, rd_busy=0.
- Dual-write collision (NUM_WR=2): port0 writes 0xA, port1 writes 0xB, both to r3. Required: r3 reads 0xB next cycle, and also same cycle when bypassed.
- Scoreboard: reserve r9 at cycle t. Required: rd_busy=1 from t+1. A write of 0x55 to r9 at t+3 gives rd_busy=0 in cycle t+3 (BYPASS=1) and busy_vec[9]=0 from t+4.
- Simultaneous reserve and write of r9. Required: r9 holds the written data and busy_vec[9]=1 the next cycle.
